// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared types and constants for the front-panel LED blink
//                scheduler: FSM state encoding, default tick timing for a
//                20 MHz clock and well-known status source indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    // Blink sequencer states; 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } led_state_e;

    // 100 ms blink tick at 20 MHz.
    localparam int TICK_DIV_20M_100MS = 2000000;

    // Default phase lengths, in ticks.
    localparam int ON_TICKS_DFLT  = 2;
    localparam int OFF_TICKS_DFLT = 2;
    localparam int GAP_TICKS_DFLT = 10;

    // Status source indices on the shared LED.
    localparam int SRC_DSP_ERR  = 0;
    localparam int SRC_OPTOLOCK = 1;
    localparam int SRC_FASTLOCK = 2;
    localparam int SRC_SPARE    = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_tick_gen
//  Description : Blink-tick prescaler. Counts 0..TICK_DIV-1 and emits a
//                one-cycle tick while the count sits at TICK_DIV-1.
//  Ports       : clk_20M  - system clock
//                reset_n  - asynchronous active-low reset
//                restart  - forces the count back to 0 at the next edge
//                tick     - one-cycle pulse every TICK_DIV cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module led_tick_gen #(
    parameter int TICK_DIV = 2000000
) (
    input  logic clk_20M,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_20M or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : led_tick_gen
`default_nettype wire

// File: rtl/led_blink_sched.sv
`default_nettype none
// ============================================================================
//  Module      : led_blink_sched
//  Description : Shares one status LED among N_SRC sticky status sources.
//                Source i is shown as i+1 blinks followed by a long dark gap;
//                pending sources are served round-robin until cleared.
//  Ports       : clk_20M  - system clock (20 MHz)
//                reset_n  - asynchronous active-low reset
//                evt_in   - per-source event, sets pending
//                clr      - per-source clear (set wins on collision)
//                led_out  - registered LED drive, 1 = lit
//                busy     - registered, high whenever not IDLE
//                cur_src  - source currently (or last) displayed
//                pending  - sticky pending flags
//  Revision    : 1.0 - initial release
// ============================================================================
module led_blink_sched
    import led_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int TICK_DIV  = TICK_DIV_20M_100MS,
    parameter int ON_TICKS  = ON_TICKS_DFLT,
    parameter int OFF_TICKS = OFF_TICKS_DFLT,
    parameter int GAP_TICKS = GAP_TICKS_DFLT,
    localparam int SW       = $clog2(N_SRC)
) (
    input  logic             clk_20M,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] evt_in,
    input  logic [N_SRC-1:0] clr,
    output logic             led_out,
    output logic             busy,
    output logic [SW-1:0]    cur_src,
    output logic [N_SRC-1:0] pending
);

    localparam int MAX_T = max3(ON_TICKS, OFF_TICKS, GAP_TICKS);
    localparam int PH_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_TICKS - 1);
    localparam logic [SW-1:0]   RR_INIT  = SW'(N_SRC - 1);

    led_state_e       state_q, state_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [SW-1:0]    rr_q, rr_d;
    logic [SW-1:0]    cur_q, cur_d;
    logic [SW:0]      blink_q, blink_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             led_q, led_d;
    logic             busy_q, busy_d;

    logic             w_tick;
    logic             w_restart;
    logic             w_found;
    logic [SW-1:0]    w_grant;
    logic [SW-1:0]    w_idx;
    logic             w_abort;
    logic             w_phase_last;

    // Set has priority over clear.
    assign pending_d = (pending_q & ~clr) | evt_in;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_20M (clk_20M),
        .reset_n (reset_n),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // Round-robin: first pending bit after the last granted source, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            w_idx = SW'((int'(rr_q) + k) % N_SRC);
            if (!w_found && pending_q[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_comb begin
        case (state_q)
            ON:      w_phase_last = (phase_q == ON_LAST);
            OFF:     w_phase_last = (phase_q == OFF_LAST);
            GAP:     w_phase_last = (phase_q == GAP_LAST);
            default: w_phase_last = 1'b0;
        endcase
    end

    // Looking at the next pending value lets a clear cut the blink at the
    // very edge it is sampled on.
    assign w_abort = ((state_q == ON) || (state_q == OFF)) && !pending_d[cur_q];

    // State register
    always_ff @(posedge clk_20M or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            rr_q      <= RR_INIT;
            cur_q     <= '0;
            blink_q   <= '0;
            phase_q   <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            cur_q     <= cur_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cur_d     = cur_q;
        blink_d   = blink_q;
        phase_d   = phase_q;
        w_restart = 1'b0;
        if (w_abort) begin
            state_d   = GAP;
            phase_d   = '0;
            w_restart = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_found) begin
                        state_d   = ON;
                        cur_d     = w_grant;
                        rr_d      = w_grant;
                        blink_d   = {1'b0, w_grant} + 1'b1;
                        phase_d   = '0;
                        w_restart = 1'b1;
                    end
                end
                ON: begin
                    if (w_tick) begin
                        if (w_phase_last) begin
                            state_d = OFF;
                            blink_d = blink_q - 1'b1;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end
                end
                OFF: begin
                    if (w_tick) begin
                        if (w_phase_last) begin
                            state_d = (blink_q != '0) ? ON : GAP;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (w_tick) begin
                        if (w_phase_last) begin
                            state_d = IDLE;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output logic, registered together with the state.
    always_comb begin
        led_d  = (state_d == ON);
        busy_d = (state_d != IDLE);
    end

    assign led_out = led_q;
    assign busy    = busy_q;
    assign cur_src = cur_q;
    assign pending = pending_q;

endmodule : led_blink_sched
`default_nettype wire

// File: tb/tb_led_blink_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_blink_sched
//  Description : Directed self-checking bench for led_blink_sched with
//                TICK_DIV=4, ON=2, OFF=2, GAP=10 (8/8/40-cycle phases).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_blink_sched;

    localparam int N_SRC   = 4;
    localparam int ON_CYC  = 8;
    localparam int OFF_CYC = 8;
    localparam int GAP_CYC = 40;

    logic             clk_20M;
    logic             reset_n;
    logic [N_SRC-1:0] evt_in;
    logic [N_SRC-1:0] clr;
    logic             led_out;
    logic             busy;
    logic [1:0]       cur_src;
    logic [N_SRC-1:0] pending;

    int n_checks;
    int n_errors;

    led_blink_sched #(
        .N_SRC     (N_SRC),
        .TICK_DIV  (4),
        .ON_TICKS  (2),
        .OFF_TICKS (2),
        .GAP_TICKS (10)
    ) u_dut (
        .clk_20M (clk_20M),
        .reset_n (reset_n),
        .evt_in  (evt_in),
        .clr     (clr),
        .led_out (led_out),
        .busy    (busy),
        .cur_src (cur_src),
        .pending (pending)
    );

    initial clk_20M = 1'b0;
    always #25 clk_20M = ~clk_20M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_20M);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        evt_in  = '0;
        clr     = '0;
        step();
        step();
        reset_n = 1'b1;
        chk("rst_led", led_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pend", pending, 0);
        chk("rst_cur", cur_src, 0);
    endtask

    // Called just after the grant edge; consumes one full code plus gap
    // and the single IDLE cycle, leaving time just after the next edge.
    task automatic expect_code(input string tag, input int src);
        chk({tag, "_cur"}, cur_src, src);
        chk({tag, "_busy"}, busy, 1);
        for (int b = 0; b < src + 1; b++) begin
            for (int c = 0; c < ON_CYC; c++) begin
                chk({tag, "_on"}, led_out, 1);
                step();
            end
            for (int c = 0; c < OFF_CYC; c++) begin
                chk({tag, "_off"}, led_out, 0);
                step();
            end
        end
        for (int c = 0; c < GAP_CYC; c++) begin
            chk({tag, "_gap_led"}, led_out, 0);
            chk({tag, "_gap_busy"}, busy, 1);
            step();
        end
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_cur"}, cur_src, src);
        step();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        evt_in   = '1;
        clr      = '0;

        // 1. Reset holds everything low even with events present.
        step();
        step();
        chk("t1_led", led_out, 0);
        chk("t1_busy", busy, 0);
        chk("t1_pend", pending, 4'b0000);
        reset_n = 1'b1;
        step();
        evt_in = '0;
        chk("t1_pend_rel", pending, 4'b1111);
        chk("t1_busy_rel", busy, 0);
        chk("t1_led_rel", led_out, 0);

        // 2. Single source 2: three blinks, gap, repeat.
        do_reset();
        evt_in = 4'b0100;
        step();
        evt_in = '0;
        chk("t2_pend", pending, 4'b0100);
        chk("t2_led_pre", led_out, 0);
        chk("t2_busy_pre", busy, 0);
        step();
        expect_code("t2", 2);
        chk("t2_pend_after", pending, 4'b0100);
        chk("t2_rep_led", led_out, 1);
        chk("t2_rep_cur", cur_src, 2);

        // 3. Round-robin between sources 0 and 3.
        do_reset();
        evt_in = 4'b1001;
        step();
        evt_in = '0;
        step();
        expect_code("t3a", 0);
        expect_code("t3b", 3);
        chk("t3_back_cur", cur_src, 0);
        chk("t3_back_led", led_out, 1);

        // 4. Abort on clear during the third ON cycle of source 1.
        do_reset();
        evt_in = 4'b0010;
        step();
        evt_in = '0;
        step();
        chk("t4_cur", cur_src, 1);
        chk("t4_on1", led_out, 1);
        step();
        step();
        chk("t4_on3", led_out, 1);
        clr = 4'b0010;
        step();
        clr = '0;
        chk("t4_abort_led", led_out, 0);
        chk("t4_abort_pend", pending, 4'b0000);
        for (int c = 0; c < GAP_CYC; c++) begin
            chk("t4_gap_busy", busy, 1);
            chk("t4_gap_led", led_out, 0);
            step();
        end
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_pend", pending, 4'b0000);
        step();
        chk("t4_idle2_busy", busy, 0);

        // 5. Set and clear together: set wins, and no abort while showing.
        do_reset();
        evt_in = 4'b0010;
        clr    = 4'b0010;
        step();
        chk("t5_pend", pending, 4'b0010);
        step();
        chk("t5_grant_led", led_out, 1);
        chk("t5_grant_cur", cur_src, 1);
        step();
        chk("t5_hold_led", led_out, 1);
        chk("t5_hold_pend", pending, 4'b0010);
        evt_in = '0;
        clr    = '0;
        step();

        // 6. Asynchronous reset mid-ON, then arbitration restarts at source 0.
        chk("t6_pre_led", led_out, 1);
        #5;
        reset_n = 1'b0;
        #2;
        chk("t6_async_led", led_out, 0);
        chk("t6_async_pend", pending, 4'b0000);
        chk("t6_async_busy", busy, 0);
        #2;
        reset_n = 1'b1;
        evt_in  = 4'b1111;
        step();
        evt_in = '0;
        chk("t6_pend", pending, 4'b1111);
        step();
        chk("t6_cur", cur_src, 0);
        chk("t6_led", led_out, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_led_blink_sched
`default_nettype wire
